// File: rtl/riscv_pkg.sv
// Shared RV32I control constants for the branch resolve path: opcodes,
// branch funct3 encodings and the flush FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_t;

  typedef enum logic [0:0] {
    FS_IDLE  = 1'b0,
    FS_FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-stage request, PC-select response and flush/debug signals of the
// branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    // Both sides use valid/ready: a beat transfers on a rising clock edge where
    // valid && ready; once valid is raised the payload holds until that edge.
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;
    logic            eq;
    logic            lts;
    logic            ltu;
    logic            pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            mispredict;
    logic            illegal;
    logic            flush;
    logic            dbg_state;

    modport master (
        output in_valid, opcode, funct3, pc, rs1, imm_b, imm_j, imm_i,
               eq, lts, ltu, pred_taken, out_ready,
        input  in_ready, out_valid, taken, target, mispredict, illegal,
               flush, dbg_state
    );

    modport slave (
        input  in_valid, opcode, funct3, pc, rs1, imm_b, imm_j, imm_i,
               eq, lts, ltu, pred_taken, out_ready,
        output in_ready, out_valid, taken, target, mispredict, illegal,
               flush, dbg_state
    );
endinterface

// File: rtl/branch_resolve_unit_decide.sv
// Conditional-branch decision: maps funct3 and the comparator flags to a
// taken bit and flags the two reserved funct3 codes as illegal.
module branch_decide
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lts,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (br_f3_t'(funct3))
            F3_BEQ:           taken   = eq;
            F3_BNE:           taken   = !eq;
            F3_BLT:           taken   = lts;
            F3_BGE:           taken   = !lts;
            F3_BLTU:          taken   = ltu;
            F3_BGEU:          taken   = !ltu;
            F3_RSV2, F3_RSV3: illegal = 1'b1;
            default:          ;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV32I branches/jumps, registers the decision in one valid/ready
// stage and requests a fixed-length pipeline flush on a retired mispredict.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int          CW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [0:0]  IDLE  = FS_IDLE;
    localparam logic [0:0]  FLUSH = FS_FLUSH;

    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic            out_valid_q;
    logic            taken_q;
    logic [XLEN-1:0] target_q;
    logic            mis_q;
    logic            illegal_q;

    logic            br_taken;
    logic            br_illegal;
    logic            dec_taken;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_target;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jal_target;
    logic [XLEN-1:0] jalr_sum;
    logic            in_ready;
    logic            accept;
    logic            retire;

    branch_decide u_decide (
        .funct3  (bus.funct3),
        .eq      (bus.eq),
        .lts     (bus.lts),
        .ltu     (bus.ltu),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    // All target adders wrap modulo 2^XLEN.
    assign pc_plus4   = bus.pc + XLEN'(4);
    assign br_target  = bus.pc + bus.imm_b;
    assign jal_target = bus.pc + bus.imm_j;
    assign jalr_sum   = bus.rs1 + bus.imm_i;

    always_comb begin
        dec_taken   = 1'b0;
        dec_illegal = 1'b0;
        dec_target  = pc_plus4;
        case (bus.opcode)
            OP_BRANCH: begin
                dec_taken   = br_taken;
                dec_illegal = br_illegal;
                if (br_taken) dec_target = br_target;
            end
            OP_JAL: begin
                dec_taken  = 1'b1;
                dec_target = jal_target;
            end
            OP_JALR: begin
                dec_taken  = 1'b1;
                dec_target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    assign in_ready = (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign retire   = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            mis_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            taken_q     <= dec_taken;
            target_q    <= dec_target;
            mis_q       <= dec_taken != bus.pred_taken;
            illegal_q   <= dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // FLUSH is held for exactly FLUSH_CYCLES cycles: load N-1, leave at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (retire && mis_q) begin
                        state <= FLUSH;
                        cnt   <= CW'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.taken      = taken_q;
    assign bus.target     = target_q;
    assign bus.mispredict = out_valid_q && mis_q;
    assign bus.illegal    = illegal_q;
    assign bus.flush      = (state == FLUSH);
    assign bus.dbg_state  = state;
endmodule
